// File: rtl/vga_pkg.sv
// Shared defaults and types for the VGA pixel-stream blocks.
// Widths default to a 640x480 raster with 12-bit pixels.
package vga_pkg;

    localparam int DEF_WIDTH            = 640;
    localparam int DEF_HEIGHT           = 480;
    localparam int DEF_WIDTH_BITS       = 10;
    localparam int DEF_HEIGHT_BITS      = 9;
    localparam int DEF_PIXEL_BITS       = 12;
    localparam int DEF_CHECKSUM_BITS    = 16;
    localparam int DEF_FRAME_COUNT_BITS = 8;

    typedef enum logic {
        UNSYNCED = 1'b0,
        ACTIVE   = 1'b1
    } monitor_state_t;

    // Per-frame result flags; the numeric results are parameter-sized and live beside it.
    typedef struct packed {
        logic order_error;
        logic size_error;
    } frame_result_t;

endpackage

// File: rtl/raster_tracker.sv
// Expected-coordinate counter for a raster stream: flags pixels whose (x,y)
// differs from the expected position and resynchronises to the received one.
module raster_tracker
    import vga_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int HEIGHT      = DEF_HEIGHT,
    parameter int WIDTH_BITS  = DEF_WIDTH_BITS,
    parameter int HEIGHT_BITS = DEF_HEIGHT_BITS,
    parameter bit CHECK_ORDER = 1'b1
) (
    input  logic                   clock_in,
    input  logic                   reset_n_in,
    input  logic                   accept,
    input  logic                   clear,
    input  logic [WIDTH_BITS-1:0]  pixel_x,
    input  logic [HEIGHT_BITS-1:0] pixel_y,
    output logic                   mismatch
);

    localparam logic [WIDTH_BITS-1:0]  X_LAST = WIDTH_BITS'(WIDTH - 1);
    localparam logic [HEIGHT_BITS-1:0] Y_LAST = HEIGHT_BITS'(HEIGHT - 1);

    logic [WIDTH_BITS-1:0]  ex_q, ex_nx, base_x;
    logic [HEIGHT_BITS-1:0] ey_q, ey_nx, base_y;

    // Advance from the received position after a mismatch, otherwise from the expected one.
    always_comb begin
        mismatch = CHECK_ORDER && accept && ((pixel_x != ex_q) || (pixel_y != ey_q));
        base_x   = mismatch ? pixel_x : ex_q;
        base_y   = mismatch ? pixel_y : ey_q;
        ex_nx    = base_x + 1'b1;
        ey_nx    = base_y;
        if (base_x >= X_LAST) begin
            ex_nx = '0;
            ey_nx = (base_y >= Y_LAST) ? '0 : base_y + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            ex_q <= '0;
            ey_q <= '0;
        end else if (clear) begin
            ex_q <= '0;
            ey_q <= '0;
        end else if (accept) begin
            ex_q <= ex_nx;
            ey_q <= ey_nx;
        end
    end

endmodule

// File: rtl/frame_monitor.sv
// Pixel-stream monitor: accumulates per-frame count, lit count and checksum,
// checks raster order, and reports one result record per v_sync falling edge.
module frame_monitor
    import vga_pkg::*;
#(
    parameter int WIDTH            = DEF_WIDTH,
    parameter int HEIGHT           = DEF_HEIGHT,
    parameter int WIDTH_BITS       = DEF_WIDTH_BITS,
    parameter int HEIGHT_BITS      = DEF_HEIGHT_BITS,
    parameter int PIXEL_BITS       = DEF_PIXEL_BITS,
    parameter int CHECKSUM_BITS    = DEF_CHECKSUM_BITS,
    parameter int FRAME_COUNT_BITS = DEF_FRAME_COUNT_BITS,
    parameter bit CHECK_ORDER      = 1'b1,
    parameter int COUNT_BITS       = $clog2(WIDTH * HEIGHT + 1)
) (
    input  logic                        clock_in,
    input  logic                        reset_n_in,
    input  logic [WIDTH_BITS-1:0]       pixel_x_in,
    input  logic [HEIGHT_BITS-1:0]      pixel_y_in,
    input  logic [PIXEL_BITS-1:0]       pixel_in,
    input  logic                        video_on_in,
    input  logic                        v_sync_in,
    output logic                        frame_valid_out,
    output logic [CHECKSUM_BITS-1:0]    checksum_out,
    output logic [COUNT_BITS-1:0]       pixel_count_out,
    output logic [COUNT_BITS-1:0]       lit_count_out,
    output logic [FRAME_COUNT_BITS-1:0] frame_count_out,
    output logic                        order_error_out,
    output logic                        size_error_out,
    output logic [WIDTH_BITS-1:0]       first_err_x_out,
    output logic [HEIGHT_BITS-1:0]      first_err_y_out
);

    localparam logic [COUNT_BITS-1:0] FRAME_SIZE = COUNT_BITS'(WIDTH * HEIGHT);

    monitor_state_t state_q;
    logic           v_sync_q;
    logic           v_sync_fall;
    logic           accept;
    logic           mismatch;

    logic [COUNT_BITS-1:0]    count_q, count_nx;
    logic [COUNT_BITS-1:0]    lit_q, lit_nx;
    logic [CHECKSUM_BITS-1:0] sum_q, sum_nx;
    logic                     err_q;
    logic [WIDTH_BITS-1:0]    first_x_q, first_x_nx;
    logic [HEIGHT_BITS-1:0]   first_y_q, first_y_nx;
    frame_result_t            flags_nx;

    assign v_sync_fall = v_sync_q && !v_sync_in;
    assign accept      = (state_q == ACTIVE) && video_on_in;

    raster_tracker #(
        .WIDTH       (WIDTH),
        .HEIGHT      (HEIGHT),
        .WIDTH_BITS  (WIDTH_BITS),
        .HEIGHT_BITS (HEIGHT_BITS),
        .CHECK_ORDER (CHECK_ORDER)
    ) u_tracker (
        .clock_in   (clock_in),
        .reset_n_in (reset_n_in),
        .accept     (accept),
        .clear      (v_sync_fall),
        .pixel_x    (pixel_x_in),
        .pixel_y    (pixel_y_in),
        .mismatch   (mismatch)
    );

    // Next-state accumulators include the current pixel so a pixel on the fall edge closes into this frame.
    always_comb begin
        count_nx   = count_q;
        lit_nx     = lit_q;
        sum_nx     = sum_q;
        first_x_nx = first_x_q;
        first_y_nx = first_y_q;
        if (accept) begin
            if (count_q != '1) count_nx = count_q + 1'b1;
            if ((pixel_in == '1) && (lit_q != '1)) lit_nx = lit_q + 1'b1;
            sum_nx = sum_q + CHECKSUM_BITS'(pixel_in);
        end
        if (mismatch && !err_q) begin
            first_x_nx = pixel_x_in;
            first_y_nx = pixel_y_in;
        end
        flags_nx.order_error = err_q || mismatch;
        flags_nx.size_error  = (count_nx != FRAME_SIZE);
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q         <= UNSYNCED;
            v_sync_q        <= 1'b1;
            count_q         <= '0;
            lit_q           <= '0;
            sum_q           <= '0;
            err_q           <= 1'b0;
            first_x_q       <= '0;
            first_y_q       <= '0;
            frame_valid_out <= 1'b0;
            checksum_out    <= '0;
            pixel_count_out <= '0;
            lit_count_out   <= '0;
            frame_count_out <= '0;
            order_error_out <= 1'b0;
            size_error_out  <= 1'b0;
            first_err_x_out <= '0;
            first_err_y_out <= '0;
        end else begin
            v_sync_q        <= v_sync_in;
            frame_valid_out <= 1'b0;
            if (state_q == UNSYNCED) begin
                // The first fall only establishes frame alignment; nothing is reported.
                if (v_sync_fall) state_q <= ACTIVE;
            end else if (v_sync_fall) begin
                frame_valid_out <= 1'b1;
                checksum_out    <= sum_nx;
                pixel_count_out <= count_nx;
                lit_count_out   <= lit_nx;
                frame_count_out <= frame_count_out + 1'b1;
                order_error_out <= flags_nx.order_error;
                size_error_out  <= flags_nx.size_error;
                first_err_x_out <= first_x_nx;
                first_err_y_out <= first_y_nx;
                count_q         <= '0;
                lit_q           <= '0;
                sum_q           <= '0;
                err_q           <= 1'b0;
                first_x_q       <= '0;
                first_y_q       <= '0;
            end else begin
                count_q   <= count_nx;
                lit_q     <= lit_nx;
                sum_q     <= sum_nx;
                err_q     <= flags_nx.order_error;
                first_x_q <= first_x_nx;
                first_y_q <= first_y_nx;
            end
        end
    end

endmodule

// File: tb/tb_frame_monitor.sv
// Directed bench for frame_monitor on a reduced 16x12 raster; a second
// instance with a 2-bit frame counter shares the stimulus to exercise wrap.
module tb_frame_monitor;

    localparam int W = 16;
    localparam int H = 12;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  px = '0;
    logic [8:0]  py = '0;
    logic [11:0] pix = '0;
    logic        von = 1'b0;
    logic        vs = 1'b1;

    logic        fv, oe, se, fv2, oe2, se2;
    logic [15:0] cs, cs2;
    logic [7:0]  pc, lc, fc, pc2, lc2;
    logic [1:0]  fc2;
    logic [9:0]  fx, fx2;
    logic [8:0]  fy, fy2;

    int errors = 0;
    int checks = 0;
    int pulses;

    always #5 clk = ~clk;

    frame_monitor #(.WIDTH(W), .HEIGHT(H)) dut (
        .clock_in (clk), .reset_n_in (rst_n),
        .pixel_x_in (px), .pixel_y_in (py), .pixel_in (pix),
        .video_on_in (von), .v_sync_in (vs),
        .frame_valid_out (fv), .checksum_out (cs),
        .pixel_count_out (pc), .lit_count_out (lc),
        .frame_count_out (fc), .order_error_out (oe),
        .size_error_out (se), .first_err_x_out (fx), .first_err_y_out (fy)
    );

    frame_monitor #(.WIDTH(W), .HEIGHT(H), .FRAME_COUNT_BITS(2)) dut2 (
        .clock_in (clk), .reset_n_in (rst_n),
        .pixel_x_in (px), .pixel_y_in (py), .pixel_in (pix),
        .video_on_in (von), .v_sync_in (vs),
        .frame_valid_out (fv2), .checksum_out (cs2),
        .pixel_count_out (pc2), .lit_count_out (lc2),
        .frame_count_out (fc2), .order_error_out (oe2),
        .size_error_out (se2), .first_err_x_out (fx2), .first_err_y_out (fy2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Streams one raster frame; grid frames light columns 0,8,15 and rows 0,6,11.
    task automatic send_frame(input int skip_x, input int skip_y, input bit grid,
                              input logic [11:0] fill, input bit last_on_fall,
                              input int stop_after);
        int n = 0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                if (n == stop_after) return;
                if (x == skip_x && y == skip_y) continue;
                @(negedge clk);
                px  = 10'(x);
                py  = 9'(y);
                von = 1'b1;
                if (grid)
                    pix = (x == 0 || x == 8 || x == 15 || y == 0 || y == 6 || y == 11) ? 12'hFFF : 12'h000;
                else
                    pix = fill;
                vs = !(last_on_fall && x == W - 1 && y == H - 1);
                n++;
            end
        end
    endtask

    // Holds v_sync low for a few cycles and counts frame_valid pulses seen meanwhile.
    task automatic close_frame(output int n_pulses);
        n_pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (fv) n_pulses++;
            von = 1'b0;
            vs  = 1'b0;
        end
        @(negedge clk);
        if (fv) n_pulses++;
        vs = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_fv", 32'(fv), 0);
        chk("rst_cs", 32'(cs), 0);
        chk("rst_pc", 32'(pc), 0);
        chk("rst_lc", 32'(lc), 0);
        chk("rst_fc", 32'(fc), 0);
        chk("rst_oe", 32'(oe), 0);
        chk("rst_se", 32'(se), 0);
        chk("rst_fx", 32'(fx), 0);
        chk("rst_fy", 32'(fy), 0);
        chk("rst2_all", {fv2, cs2, pc2, lc2}, 0);
        chk("rst2_misc", {fc2, oe2, se2, fx2, fy2}, 0);
        rst_n = 1'b1;

        // Frame before any sync: ignored, and the closing fall only aligns.
        send_frame(-1, -1, 1'b1, 12'h000, 1'b0, -1);
        close_frame(pulses);
        chk("unsync_pulses", 32'(pulses), 0);
        chk("unsync_fc", 32'(fc), 0);
        chk("unsync_pc", 32'(pc), 0);

        // Grid: lit = 3*12 + 3*16 - 9 = 75; checksum = 75*4095 mod 2^16 = 0xAFB5.
        send_frame(-1, -1, 1'b1, 12'h000, 1'b0, -1);
        close_frame(pulses);
        chk("grid_pulses", 32'(pulses), 1);
        chk("grid_pc", 32'(pc), 192);
        chk("grid_lc", 32'(lc), 75);
        chk("grid_cs", 32'(cs), 32'hAFB5);
        chk("grid_oe", 32'(oe), 0);
        chk("grid_se", 32'(se), 0);
        chk("grid_fc", 32'(fc), 1);
        chk("grid_fc2", 32'(fc2), 1);

        // Pixel (5,0) missing: first mismatch is received (6,0).
        send_frame(5, 0, 1'b0, 12'h001, 1'b0, -1);
        close_frame(pulses);
        chk("skip_pulses", 32'(pulses), 1);
        chk("skip_oe", 32'(oe), 1);
        chk("skip_fx", 32'(fx), 6);
        chk("skip_fy", 32'(fy), 0);
        chk("skip_se", 32'(se), 1);
        chk("skip_pc", 32'(pc), 191);
        chk("skip_cs", 32'(cs), 32'h00BF);
        chk("skip_lc", 32'(lc), 0);
        chk("skip_fc2", 32'(fc2), 2);

        // Clean frame after the error: 192 * 0x123 = 0xDA40.
        send_frame(-1, -1, 1'b0, 12'h123, 1'b0, -1);
        close_frame(pulses);
        chk("clean_oe", 32'(oe), 0);
        chk("clean_se", 32'(se), 0);
        chk("clean_fx", 32'(fx), 0);
        chk("clean_pc", 32'(pc), 192);
        chk("clean_cs", 32'(cs), 32'hDA40);
        chk("clean_fc2", 32'(fc2), 3);

        // Last pixel lands on the fall edge: 192 * 4095 mod 2^16 = 0xFF40.
        send_frame(-1, -1, 1'b0, 12'hFFF, 1'b1, -1);
        close_frame(pulses);
        chk("edge_pulses", 32'(pulses), 1);
        chk("edge_pc", 32'(pc), 192);
        chk("edge_lc", 32'(lc), 192);
        chk("edge_cs", 32'(cs), 32'hFF40);
        chk("edge_se", 32'(se), 0);
        chk("edge_oe", 32'(oe), 0);
        chk("edge_fc", 32'(fc), 4);
        chk("edge_fc2", 32'(fc2), 0);

        send_frame(-1, -1, 1'b1, 12'h000, 1'b0, -1);
        close_frame(pulses);
        chk("f5_fc", 32'(fc), 5);
        chk("f5_fc2", 32'(fc2), 1);
        repeat (3) @(negedge clk);
        chk("hold_pc", 32'(pc), 192);
        chk("hold_lc", 32'(lc), 75);

        // One-cycle reset mid-frame discards the partial frame.
        send_frame(-1, -1, 1'b1, 12'h000, 1'b0, 40);
        @(negedge clk);
        von   = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mrst_pc", 32'(pc), 0);
        chk("mrst_lc", 32'(lc), 0);
        chk("mrst_cs", 32'(cs), 0);
        chk("mrst_fc", 32'(fc), 0);
        chk("mrst_flags", {fv, oe, se}, 0);
        chk("mrst_fc2", 32'(fc2), 0);
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(-1, -1, 1'b1, 12'h000, 1'b0, -1);
        close_frame(pulses);
        chk("mrst_pulses", 32'(pulses), 0);
        chk("mrst_fc_after", 32'(fc), 0);
        chk("mrst_pc_after", 32'(pc), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
